// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side bundle for the hazard/stall controller: hazard inputs in,
// latch enables, flushes and status out.
interface hazard_stall_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  i_ID_EX_mem_read;
  logic [REG_ADDR_W-1:0] i_ID_EX_rt;
  logic [REG_ADDR_W-1:0] i_IF_ID_rs;
  logic [REG_ADDR_W-1:0] i_IF_ID_rt;
  logic                  i_branch_taken;
  logic                  i_halt_id;
  logic                  i_debug_mode;
  logic                  i_step;
  logic                  o_stage_en;
  logic                  o_write_pc;
  logic                  o_write_IF_ID;
  logic                  o_flush_IF_ID;
  logic                  o_flush_ID_EX;
  logic                  o_halted;
  logic [CNT_W-1:0]      o_stall_cnt;

  modport master (
    output i_ID_EX_mem_read, i_ID_EX_rt, i_IF_ID_rs, i_IF_ID_rt,
           i_branch_taken, i_halt_id, i_debug_mode, i_step,
    input  o_stage_en, o_write_pc, o_write_IF_ID, o_flush_IF_ID,
           o_flush_ID_EX, o_halted, o_stall_cnt
  );

  modport slave (
    input  i_ID_EX_mem_read, i_ID_EX_rt, i_IF_ID_rs, i_IF_ID_rt,
           i_branch_taken, i_halt_id, i_debug_mode, i_step,
    output o_stage_en, o_write_pc, o_write_IF_ID, o_flush_IF_ID,
           o_flush_ID_EX, o_halted, o_stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall / branch flush control with single-step debug and a
// HALT drain sequence for a 5-stage pipeline.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16
) (
  input logic            clk,
  input logic            rst,
  hazard_stall_ctrl_if.slave bus
);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {RUN, STEP_WAIT, STEP_EXEC, DRAIN, HALTED} state_t;

  state_t           state_reg;
  logic [DW-1:0]    drain_cnt_reg;
  logic [CNT_W-1:0] stall_cnt_reg;
  logic             halted_reg;

  logic lu;
  logic active;
  logic stall;
  logic stage_en;
  logic write_pc;
  logic flush_if_id;
  logic flush_id_ex;

  assign lu = bus.i_ID_EX_mem_read && (bus.i_ID_EX_rt != '0) &&
              ((bus.i_ID_EX_rt == bus.i_IF_ID_rs) || (bus.i_ID_EX_rt == bus.i_IF_ID_rt));
  assign active = (state_reg == RUN) || (state_reg == STEP_EXEC);
  assign stall  = active && lu;

  // Reset also gates the outputs, since the held state is RUN while rst is high.
  always_comb begin
    stage_en    = 1'b0;
    write_pc    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst) begin
      case (state_reg)
        RUN, STEP_EXEC: begin
          stage_en    = 1'b1;
          write_pc    = !lu;
          flush_id_ex = lu;
          flush_if_id = !lu && bus.i_branch_taken;
        end
        DRAIN: begin
          stage_en    = 1'b1;
          flush_id_ex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      stall_cnt_reg <= '0;
      halted_reg    <= 1'b0;
    end else begin
      if (stall && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      case (state_reg)
        RUN: begin
          if (bus.i_halt_id) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= DRAIN_LOAD;
          end else if (bus.i_debug_mode) begin
            state_reg <= STEP_WAIT;
          end
        end
        STEP_WAIT: begin
          if (bus.i_step)
            state_reg <= STEP_EXEC;
          else if (!bus.i_debug_mode)
            state_reg <= RUN;
        end
        STEP_EXEC: begin
          if (bus.i_halt_id) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= DRAIN_LOAD;
          end else if (bus.i_debug_mode) begin
            state_reg <= STEP_WAIT;
          end else begin
            state_reg <= RUN;
          end
        end
        DRAIN: begin
          if (drain_cnt_reg == '0) begin
            state_reg  <= HALTED;
            halted_reg <= 1'b1;
          end else begin
            drain_cnt_reg <= drain_cnt_reg - DW'(1);
          end
        end
        HALTED: ;
        default: state_reg <= RUN;
      endcase
    end
  end

  assign bus.o_stage_en    = stage_en;
  assign bus.o_write_pc    = write_pc;
  assign bus.o_write_IF_ID = write_pc;
  assign bus.o_flush_IF_ID = flush_if_id;
  assign bus.o_flush_ID_EX = flush_id_ex;
  assign bus.o_halted      = halted_reg;
  assign bus.o_stall_cnt   = stall_cnt_reg;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random stimulus against
// a mode-based reference model; a second instance uses a 2-bit stall counter.
module tb_hazard_stall_ctrl;
  localparam int DRAIN_N = 4;
  localparam int SAT_MAX = 3;
  localparam int M_RUN = 0, M_WAIT = 1, M_EXEC = 2, M_DRAIN = 3, M_HALT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       mr = 1'b0, br = 1'b0, halt = 1'b0, dbg = 1'b0, step = 1'b0;
  logic [4:0] ex_rt = '0, rs = '0, rt = '0;

  hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) if_main ();
  hazard_stall_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  if_sat ();

  assign if_main.i_ID_EX_mem_read = mr;   assign if_sat.i_ID_EX_mem_read = mr;
  assign if_main.i_ID_EX_rt = ex_rt;      assign if_sat.i_ID_EX_rt = ex_rt;
  assign if_main.i_IF_ID_rs = rs;         assign if_sat.i_IF_ID_rs = rs;
  assign if_main.i_IF_ID_rt = rt;         assign if_sat.i_IF_ID_rt = rt;
  assign if_main.i_branch_taken = br;     assign if_sat.i_branch_taken = br;
  assign if_main.i_halt_id = halt;        assign if_sat.i_halt_id = halt;
  assign if_main.i_debug_mode = dbg;      assign if_sat.i_debug_mode = dbg;
  assign if_main.i_step = step;           assign if_sat.i_step = step;

  hazard_stall_ctrl #(.REG_ADDR_W(5), .DRAIN_CYCLES(DRAIN_N), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(if_main));
  hazard_stall_ctrl #(.REG_ADDR_W(5), .DRAIN_CYCLES(DRAIN_N), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(if_sat));

  int checks = 0;
  int failures = 0;

  // reference model state
  int mode = M_RUN;
  int drain_left = 0;
  int cnt_m = 0;
  int cnt_s = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] out_main();
    return {if_main.o_stage_en, if_main.o_write_pc, if_main.o_write_IF_ID,
            if_main.o_flush_IF_ID, if_main.o_flush_ID_EX, if_main.o_halted};
  endfunction

  function automatic logic [5:0] out_sat();
    return {if_sat.o_stage_en, if_sat.o_write_pc, if_sat.o_write_IF_ID,
            if_sat.o_flush_IF_ID, if_sat.o_flush_ID_EX, if_sat.o_halted};
  endfunction

  function automatic bit hazard();
    return mr && (ex_rt != 0) && (ex_rt == rs || ex_rt == rt);
  endfunction

  // Expected {stage_en, write_pc, write_IF_ID, flush_IF_ID, flush_ID_EX, halted}.
  function automatic logic [5:0] exp_vec();
    bit executing = (mode == M_RUN) || (mode == M_EXEC);
    bit stalling = executing && hazard();
    bit en = (mode != M_WAIT) && (mode != M_HALT);
    bit fwd = executing && !stalling;
    return {en, fwd, fwd, fwd && br, stalling || (mode == M_DRAIN), mode == M_HALT};
  endfunction

  task automatic advance();
    if ((mode == M_RUN || mode == M_EXEC) && hazard()) begin
      cnt_m++;
      if (cnt_s < SAT_MAX) cnt_s++;
    end
    if (mode == M_DRAIN) begin
      drain_left--;
      if (drain_left == 0) mode = M_HALT;
    end else if (mode == M_RUN || mode == M_EXEC) begin
      if (halt) begin
        mode = M_DRAIN;
        drain_left = DRAIN_N;
      end else if (dbg) mode = M_WAIT;
      else mode = M_RUN;
    end else if (mode == M_WAIT) begin
      if (step) mode = M_EXEC;
      else if (!dbg) mode = M_RUN;
    end
  endtask

  // Called just after a negedge with inputs already driven.
  task automatic tick();
    #1;
    check("outputs", {26'd0, out_main()}, {26'd0, exp_vec()});
    check("sat_outputs", {26'd0, out_sat()}, {26'd0, exp_vec()});
    check("stall_cnt", {16'd0, if_main.o_stall_cnt}, cnt_m);
    check("sat_cnt", {30'd0, if_sat.o_stall_cnt}, cnt_s);
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {26'd0, out_main()}, 32'd0);
    check({tag, "_sat"}, {26'd0, out_sat()}, 32'd0);
    check({tag, "_cnt"}, {16'd0, if_main.o_stall_cnt}, 32'd0);
    check({tag, "_satcnt"}, {30'd0, if_sat.o_stall_cnt}, 32'd0);
  endtask

  // Asserts rst between edges, checks outputs clear before and at the edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    @(posedge clk);
    #1 check_zero("rst_held");
    @(negedge clk);
    rst = 1'b0;
    mode = M_RUN; drain_left = 0; cnt_m = 0; cnt_s = 0;
  endtask

  task automatic clear_in();
    mr = 0; br = 0; halt = 0; dbg = 0; step = 0; ex_rt = 0; rs = 0; rt = 0;
  endtask

  task automatic rand_in();
    mr = 1'($urandom_range(0, 1));
    ex_rt = 5'($urandom_range(0, 3));
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    br = 1'($urandom_range(0, 1));
    step = ($urandom_range(0, 3) == 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    clear_in();

    // $zero is never a hazard
    mr = 1; ex_rt = 0; rs = 0;
    #1 check("zero_wpc", {31'd0, if_main.o_write_pc}, 32'd1);
    check("zero_flush", {31'd0, if_main.o_flush_ID_EX}, 32'd0);
    tick();
    check("zero_cnt", {16'd0, if_main.o_stall_cnt}, 32'd0);

    // load-use on r5
    ex_rt = 5; rs = 5;
    #1 check("lu_wpc", {31'd0, if_main.o_write_pc}, 32'd0);
    check("lu_wifid", {31'd0, if_main.o_write_IF_ID}, 32'd0);
    check("lu_flush", {31'd0, if_main.o_flush_ID_EX}, 32'd1);
    tick();
    check("lu_cnt", {16'd0, if_main.o_stall_cnt}, 32'd1);

    // stall wins over branch, flush follows once hazard clears
    mr = 1; ex_rt = 7; rs = 0; rt = 7; br = 1;
    #1 check("sb_fidex", {31'd0, if_main.o_flush_ID_EX}, 32'd1);
    check("sb_fifid", {31'd0, if_main.o_flush_IF_ID}, 32'd0);
    tick();
    mr = 0;
    #1 check("sb_fifid2", {31'd0, if_main.o_flush_IF_ID}, 32'd1);
    check("sb_fidex2", {31'd0, if_main.o_flush_ID_EX}, 32'd0);
    tick();

    // single step: pulses at cycles 10 and 15
    do_reset();
    clear_in();
    for (int c = 0; c <= 20; c++) begin
      dbg = 1; step = (c == 10 || c == 15);
      #1 check("step_en", {31'd0, if_main.o_stage_en}, (c == 0 || c == 11 || c == 16) ? 32'd1 : 32'd0);
      tick();
    end
    clear_in();
    tick();
    tick();

    // halt: DRAIN_N drain cycles then 50 halted cycles
    do_reset();
    clear_in();
    halt = 1;
    tick();
    halt = 0;
    for (int c = 0; c < DRAIN_N; c++) begin
      rand_in(); dbg = 1'($urandom_range(0, 1));
      #1 check("drain_flush", {31'd0, if_main.o_flush_ID_EX}, 32'd1);
      check("drain_wpc", {31'd0, if_main.o_write_pc}, 32'd0);
      tick();
    end
    for (int c = 0; c < 50; c++) begin
      rand_in(); dbg = 1'($urandom_range(0, 1)); halt = 1'($urandom_range(0, 1));
      #1 check("halted", {30'd0, if_main.o_halted, if_main.o_stage_en}, 32'd2);
      tick();
    end

    // saturation then mid-cycle reset
    do_reset();
    clear_in();
    mr = 1; ex_rt = 3; rs = 3;
    for (int c = 0; c < 5; c++) tick();
    check("sat_3", {30'd0, if_sat.o_stall_cnt}, 32'd3);
    check("nosat_5", {16'd0, if_main.o_stall_cnt}, 32'd5);
    do_reset();

    // random run with occasional halts, debug toggling and async resets
    clear_in();
    for (int n = 0; n < 3000; n++) begin
      rand_in();
      halt = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) dbg = ~dbg;
      if ((mode == M_HALT && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      else
        tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
